// File: rtl/mixcolumns_ctrl_if.sv
// Handshake bundle between the ShiftRows output, the MixColumns sequencer and AddRoundKey.
// The slave side is the sequencer; the master side is whoever feeds states in and drains results.
interface mixcolumns_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport slave (
    input  in_valid, state_in, bypass, out_ready,
    output in_ready, out_valid, state_out, busy
  );

  modport master (
    output in_valid, state_in, bypass, out_ready,
    input  in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/mixcolumns_ctrl.sv
// Full-state AES MixColumns sequencer: COLS_PER_CYCLE single-column datapaths walk the
// 128-bit state one column group per clock; a bypass flag skips mixing for the final round.

module mixcolumn (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  // Row 0 lives in the low byte of the column word.
  assign a0 = col_i[7:0];
  assign a1 = col_i[15:8];
  assign a2 = col_i[23:16];
  assign a3 = col_i[31:24];

  assign col_o[7:0]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
  assign col_o[15:8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
  assign col_o[31:24] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
endmodule

module mixcolumns_ctrl #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             rst,
  mixcolumns_ctrl_if.slave bus
);
  // Counter step and the start index of the group that contains column 3.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e                            fsm_q, fsm_d;
  logic [1:0]                      cnt_q, cnt_d;
  logic [3:0][31:0]                st_q, st_d;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_out;

  if (!(COLS_PER_CYCLE inside {1, 2, 4})) begin : g_bad_cfg
    $error("mixcolumns_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    if (COLS_PER_CYCLE == 4) begin : g_fixed
      assign col_in[g] = st_q[g];
    end else begin : g_sel
      assign col_in[g] = st_q[cnt_q + 2'(g)];
    end
    mixcolumn u_mix (
      .col_i (col_in[g]),
      .col_o (col_out[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    unique case (fsm_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          st_d  = bus.state_in;
          cnt_d = '0;
          fsm_d = bus.bypass ? DONE : RUN;
        end
      end
      RUN: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          st_d[cnt_q + 2'(g)] = col_out[g];
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          fsm_d = DONE;
          cnt_d = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.busy      = (fsm_q == RUN) || (fsm_q == DONE);
  assign bus.state_out = st_q;
endmodule

// File: tb/tb_mixcolumns_ctrl.sv
// Directed bench for mixcolumns_ctrl at COLS_PER_CYCLE = 1, 2, 4; results go through a
// scoreboard fed by a software MixColumns model and drained by an output monitor.
module tb_mixcolumns_ctrl;
  localparam logic [127:0] T1     = 128'hc6c6c6c6_01010101_5c220af2_455313db;
  localparam logic [127:0] T1_MIX = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] D4     = 128'hd4d4d4d4_d4d4d4d4_d4d4d4d4_d5d4d4d4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [3];
  logic         in_valid  [3];
  logic         bypass    [3];
  logic         out_ready [3];
  logic [127:0] state_in  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [127:0] state_out [3];

  int checks = 0, failures = 0, n_out = 0, cyc = 0, acc_cyc = 0;
  logic [127:0] sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mixcolumns_ctrl_if u_if ();
    assign u_if.in_valid  = in_valid[g];
    assign u_if.state_in  = state_in[g];
    assign u_if.bypass    = bypass[g];
    assign u_if.out_ready = out_ready[g];
    assign in_ready[g]    = u_if.in_ready;
    assign out_valid[g]   = u_if.out_valid;
    assign busy[g]        = u_if.busy;
    assign state_out[g]   = u_if.state_out;
    mixcolumns_ctrl #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (u_if.slave)
    );
  end

  // GF(2^8) multiply by a small constant via shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
    logic [7:0] p = 8'h00;
    for (int b = 0; b < 2; b++) begin
      if (((m >> b) & 1) == 1) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[32*c + 8*r +: 8];
      for (int r = 0; r < 4; r++)
        o[32*c + 8*r +: 8] = gmul(a[r], 2) ^ gmul(a[(r+1)%4], 3) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Output monitor: a handshake seen at the negedge is taken on the next posedge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1 && rst[k] === 1'b0) begin
        n_out++;
        chkb("sb_has_entry", sbq.size() > 0, 1'b1);
        if (sbq.size() > 0) chk("sb_data", state_out[k], sbq.pop_front());
      end
    end
  end

  task automatic reset_dut(input int k);
    rst[k] = 1'b1; in_valid[k] = 1'b0; bypass[k] = 1'b0; out_ready[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    sbq.delete();
    chkb("rst_in_ready", in_ready[k], 1'b1);
    chkb("rst_out_valid", out_valid[k], 1'b0);
    chkb("rst_busy", busy[k], 1'b0);
    chk("rst_state_out", state_out[k], '0);
  endtask

  // Presents s, waits (bounded) for in_ready, returns just after the accept edge.
  task automatic accept(input int k, input logic [127:0] s, input logic byp, input bit keep);
    int t = 0;
    in_valid[k] = keep; state_in[k] = s;
    while (in_ready[k] !== 1'b1 && t < 64) begin @(posedge clk); #1; t++; end
    chkb("acc_in_ready", in_ready[k], 1'b1);
    in_valid[k] = 1'b1; state_in[k] = s; bypass[k] = byp;
    sbq.push_back(byp ? s : mix_model(s));
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep) in_valid[k] = 1'b0;
    bypass[k] = 1'b0;
  endtask

  // Latency counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_out(input int k, input int exp_lat, input int hold);
    int lat = 0;
    logic [127:0] snap;
    if (hold > 0) out_ready[k] = 1'b0;
    if (exp_lat > 0) begin
      chkb("run_busy", busy[k], 1'b1);
      chkb("run_in_ready", in_ready[k], 1'b0);
    end
    while (out_valid[k] !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("latency", 128'(lat), 128'(exp_lat));
    chkb("done_busy", busy[k], 1'b1);
    snap = state_out[k];
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin in_valid[k] = 1'b1; state_in[k] = ~snap; end
      if (i == 4) in_valid[k] = 1'b0;
      @(posedge clk); #1;
      chkb("hold_valid", out_valid[k], 1'b1);
      chk("hold_data", state_out[k], snap);
      chkb("hold_in_ready", in_ready[k], 1'b0);
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    chkb("post_valid", out_valid[k], 1'b0);
    chkb("post_in_ready", in_ready[k], 1'b1);
    chkb("post_busy", busy[k], 1'b0);
  endtask

  initial begin
    int n, prev, t, n0;
    logic [127:0] s5 [3];
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; bypass[k] = 1'b0;
      out_ready[k] = 1'b1; state_in[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    for (int k = 0; k < 3; k++) begin
      n = 4 >> k;

      // Plain mix transaction
      reset_dut(k);
      accept(k, T1, 1'b0, 1'b0);
      wait_out(k, n, 0);
      chk("t1_data", state_out[k], T1_MIX);

      // Bypass: result is the input, visible right after the accept edge
      accept(k, T1, 1'b1, 1'b0);
      wait_out(k, 0, 0);
      chk("t2_data", state_out[k], T1);

      // Back-pressure with a stray in_valid pulse, then a fresh transaction
      accept(k, T1, 1'b0, 1'b0);
      wait_out(k, n, 10);
      accept(k, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      wait_out(k, n, 0);

      // Reset mid-RUN discards the in-flight state
      accept(k, T1, 1'b0, 1'b0);
      if (n > 1) begin @(posedge clk); #1; end
      rst[k] = 1'b1;
      @(posedge clk); #1;
      rst[k] = 1'b0;
      sbq.delete();
      chkb("t4_out_valid", out_valid[k], 1'b0);
      chk("t4_state_out", state_out[k], '0);
      chkb("t4_in_ready", in_ready[k], 1'b1);
      chkb("t4_busy", busy[k], 1'b0);
      repeat (n + 2) @(posedge clk);
      #1;
      chkb("t4_no_valid", out_valid[k], 1'b0);
      accept(k, D4, 1'b0, 1'b0);
      wait_out(k, n, 0);
      chk("t4_col0", 128'(state_out[k][31:0]), 128'(32'hd6d7d5d5));

      // Back-to-back with in_valid held high
      for (int i = 0; i < 3; i++) s5[i] = {$urandom, $urandom, $urandom, $urandom};
      n0 = n_out;
      prev = 0;
      for (int i = 0; i < 3; i++) begin
        accept(k, s5[i], 1'b0, 1'b1);
        if (i > 0) chk("t5_spacing", 128'(acc_cyc - prev), 128'(n + 2));
        prev = acc_cyc;
      end
      in_valid[k] = 1'b0;
      t = 0;
      while (sbq.size() != 0 && t < 64) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      chk("t5_drained", 128'(sbq.size()), 128'(0));
      chk("t5_count", 128'(n_out - n0), 128'(3));
      chkb("t5_idle", in_ready[k], 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
